// File: rtl/cache_wb_buf.sv
// Single-line writeback (victim) buffer between the data cache and the
// memory bus. It captures one dirty line with its tag and index, then
// writes it back as a single-address burst of BEATS beats (bank 0 first).
// hit_o lets the cache controller stall a refill of the line still in flight.
module cache_wb_buf #(
  parameter int TAG_W    = 20,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4,
  parameter int DATA_W   = 32,
  parameter int BEATS    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wb_req_i,
  input  logic [TAG_W-1:0]          wb_tag_i,
  input  logic [INDEX_W-1:0]        wb_index_i,
  input  logic [DATA_W*BEATS-1:0]   wb_line_i,
  output logic                      wb_ready_o,
  input  logic [TAG_W-1:0]          lookup_tag_i,
  input  logic [INDEX_W-1:0]        lookup_index_i,
  output logic                      hit_o,
  output logic                      mem_awvalid_o,
  input  logic                      mem_awready_i,
  output logic [31:0]               mem_addr_o,
  output logic                      mem_wvalid_o,
  input  logic                      mem_wready_i,
  output logic [DATA_W-1:0]         mem_wdata_o,
  output logic [3:0]                mem_wstrb_o,
  output logic                      mem_wlast_o,
  input  logic                      mem_bvalid_i,
  output logic                      mem_bready_o
);

  localparam int LINE_W = DATA_W * BEATS;
  localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  state_t              state_r;
  state_t              state_s;
  logic [BEAT_W-1:0]   beat_r;
  logic [BEAT_W-1:0]   beat_s;
  logic                capture_s;
  logic [LINE_W-1:0]   line_r;
  logic [TAG_W-1:0]    tag_r;
  logic [INDEX_W-1:0]  index_r;
  logic                hit_s;

  logic                wb_ready_r;
  logic                awvalid_r;
  logic [31:0]         addr_r;
  logic                wvalid_r;
  logic [DATA_W-1:0]   wdata_r;
  logic                wlast_r;
  logic                bready_r;

  // Select one bus beat out of a captured line; beat 0 is the lowest bank.
  function automatic logic [DATA_W-1:0] beat_sel(input logic [LINE_W-1:0] line,
                                                 input logic [BEAT_W-1:0] beat);
    return line[DATA_W*int'(beat) +: DATA_W];
  endfunction

  // Next-state and beat-counter logic for the writeback transaction.
  always_comb begin
    state_s   = state_r;
    beat_s    = beat_r;
    capture_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (wb_req_i) begin
          state_s   = ST_ADDR;
          capture_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_ADDR: begin
        if (mem_awready_i) begin
          state_s = ST_DATA;
          beat_s  = {BEAT_W{1'b0}};
        end else begin
          state_s = ST_ADDR;
        end
      end
      ST_DATA: begin
        if (mem_wready_i) begin
          if (beat_r == LAST_BEAT) begin
            state_s = ST_RESP;
            beat_s  = {BEAT_W{1'b0}};
          end else begin
            beat_s = beat_r + {{(BEAT_W-1){1'b0}}, 1'b1};
          end
        end else begin
          beat_s = beat_r;
        end
      end
      ST_RESP: begin
        if (mem_bvalid_i) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        beat_s  = {BEAT_W{1'b0}};
      end
    endcase
  end

  // State and beat counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      beat_r  <= {BEAT_W{1'b0}};
    end else begin
      state_r <= state_s;
      beat_r  <= beat_s;
    end
  end

  // Victim capture; only written on an accepted request, so a busy buffer is never overwritten.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_r  <= {LINE_W{1'b0}};
      tag_r   <= {TAG_W{1'b0}};
      index_r <= {INDEX_W{1'b0}};
    end else if (capture_s) begin
      line_r  <= wb_line_i;
      tag_r   <= wb_tag_i;
      index_r <= wb_index_i;
    end
  end

  // Bus-side outputs registered from the next state so they change only on clock edges.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_ready_r <= 1'b1;
      awvalid_r  <= 1'b0;
      addr_r     <= 32'h0000_0000;
      wvalid_r   <= 1'b0;
      wdata_r    <= {DATA_W{1'b0}};
      wlast_r    <= 1'b0;
      bready_r   <= 1'b0;
    end else begin
      wb_ready_r <= (state_s == ST_IDLE);
      awvalid_r  <= (state_s == ST_ADDR);
      wvalid_r   <= (state_s == ST_DATA);
      wlast_r    <= (state_s == ST_DATA) && (beat_s == LAST_BEAT);
      bready_r   <= (state_s == ST_RESP);
      if (capture_s) begin
        addr_r <= {wb_tag_i, wb_index_i, {OFFSET_W{1'b0}}};
      end
      if (state_s == ST_DATA) begin
        wdata_r <= beat_sel(line_r, beat_s);
      end else begin
        wdata_r <= {DATA_W{1'b0}};
      end
    end
  end

  // Pending-line match; never asserted while the buffer is empty.
  always_comb begin
    hit_s = 1'b0;
    if ((state_r != ST_IDLE) && (lookup_tag_i == tag_r) && (lookup_index_i == index_r)) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  assign wb_ready_o    = wb_ready_r;
  assign hit_o         = hit_s;
  assign mem_awvalid_o = awvalid_r;
  assign mem_addr_o    = addr_r;
  assign mem_wvalid_o  = wvalid_r;
  assign mem_wdata_o   = wdata_r;
  assign mem_wstrb_o   = 4'hF;
  assign mem_wlast_o   = wlast_r;
  assign mem_bready_o  = bready_r;

endmodule

// File: tb/tb_cache_wb_buf.sv
// Bench for cache_wb_buf: a transaction-level model (pending line as a queue
// of beats) is compared against the DUT every cycle, directed scenarios pin
// literal expectations, and a randomized phase exercises handshakes.
module tb_cache_wb_buf;

  logic         clk;
  logic         rst_n;
  logic         wb_req_i;
  logic [19:0]  wb_tag_i;
  logic [7:0]   wb_index_i;
  logic [127:0] wb_line_i;
  logic         wb_ready_o;
  logic [19:0]  lookup_tag_i;
  logic [7:0]   lookup_index_i;
  logic         hit_o;
  logic         mem_awvalid_o;
  logic         mem_awready_i;
  logic [31:0]  mem_addr_o;
  logic         mem_wvalid_o;
  logic         mem_wready_i;
  logic [31:0]  mem_wdata_o;
  logic [3:0]   mem_wstrb_o;
  logic         mem_wlast_o;
  logic         mem_bvalid_i;
  logic         mem_bready_o;

  cache_wb_buf dut (
    .clk(clk), .rst_n(rst_n),
    .wb_req_i(wb_req_i), .wb_tag_i(wb_tag_i), .wb_index_i(wb_index_i), .wb_line_i(wb_line_i),
    .wb_ready_o(wb_ready_o),
    .lookup_tag_i(lookup_tag_i), .lookup_index_i(lookup_index_i), .hit_o(hit_o),
    .mem_awvalid_o(mem_awvalid_o), .mem_awready_i(mem_awready_i), .mem_addr_o(mem_addr_o),
    .mem_wvalid_o(mem_wvalid_o), .mem_wready_i(mem_wready_i), .mem_wdata_o(mem_wdata_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_wlast_o(mem_wlast_o),
    .mem_bvalid_i(mem_bvalid_i), .mem_bready_o(mem_bready_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_mis = 0;

  // Behavioural model: a pending line is an address still to send plus a queue of beats.
  bit          m_busy;
  bit          m_aw;
  logic [31:0] m_beats[$];
  logic [19:0] m_tag;
  logic [7:0]  m_index;

  // Observed traffic on the memory side.
  logic [31:0] log_data[$];
  bit          log_last[$];
  logic [31:0] log_addr[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Model update on each clock edge, cleared by reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy = 1'b0;
      m_aw   = 1'b0;
      m_beats.delete();
    end else if (!m_busy) begin
      if (wb_req_i) begin
        m_busy  = 1'b1;
        m_aw    = 1'b1;
        m_tag   = wb_tag_i;
        m_index = wb_index_i;
        m_beats.delete();
        for (int i = 0; i < 4; i++) m_beats.push_back(wb_line_i[32*i +: 32]);
      end
    end else if (m_aw) begin
      if (mem_awready_i) m_aw = 1'b0;
    end else if (m_beats.size() != 0) begin
      if (mem_wready_i) void'(m_beats.pop_front());
    end else if (mem_bvalid_i) begin
      m_busy = 1'b0;
    end
  end

  // Memory-side monitor.
  always @(posedge clk) begin
    if (rst_n) begin
      if (mem_wvalid_o && mem_wready_i) begin
        log_data.push_back(mem_wdata_o);
        log_last.push_back(mem_wlast_o);
      end
      if (mem_awvalid_o && mem_awready_i) log_addr.push_back(mem_addr_o);
    end
  end

  // Per-cycle comparison of DUT outputs against the model.
  bit exp_wv;
  always @(negedge clk) begin
    if (rst_n) begin
      exp_wv = m_busy && !m_aw && (m_beats.size() != 0);
      chk("wb_ready", 64'(wb_ready_o), 64'(!m_busy));
      chk("awvalid", 64'(mem_awvalid_o), 64'(m_busy && m_aw));
      if (m_busy && m_aw) chk("addr", 64'(mem_addr_o), 64'({m_tag, m_index, 4'h0}));
      chk("wvalid", 64'(mem_wvalid_o), 64'(exp_wv));
      if (exp_wv) begin
        chk("wdata", 64'(mem_wdata_o), 64'(m_beats[0]));
        chk("wlast", 64'(mem_wlast_o), 64'(m_beats.size() == 1));
      end
      chk("bready", 64'(mem_bready_o), 64'(m_busy && !m_aw && (m_beats.size() == 0)));
      chk("hit", 64'(hit_o), 64'(m_busy && (lookup_tag_i == m_tag) && (lookup_index_i == m_index)));
      chk("wstrb", 64'(mem_wstrb_o), 64'(4'hF));
    end
  end

  task automatic wait_ready(input string name, output int n);
    n = 0;
    while (!wb_ready_o && n < 100) begin
      tick();
      n++;
    end
    chk({name, "_timeout"}, 64'(n < 100), 64'(1));
  endtask

  task automatic request(input logic [19:0] t, input logic [7:0] x, input logic [127:0] l);
    wb_req_i   = 1'b1;
    wb_tag_i   = t;
    wb_index_i = x;
    wb_line_i  = l;
  endtask

  task automatic clear_logs();
    log_data.delete();
    log_last.delete();
    log_addr.delete();
  endtask

  task automatic check_burst(input string name, input int base, input logic [127:0] l);
    chk({name, "_beats"}, 64'(log_data.size() >= base + 4), 64'(1));
    if (log_data.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) begin
        chk({name, "_wdata"}, 64'(log_data[base+i]), 64'(l[32*i +: 32]));
        chk({name, "_wlast"}, 64'(log_last[base+i]), 64'(i == 3));
      end
    end
  endtask

  int n;
  logic [127:0] line_a;
  logic [127:0] line_b;
  bit wpat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  initial begin
    rst_n = 1'b0;
    wb_req_i = 1'b0; wb_tag_i = '0; wb_index_i = '0; wb_line_i = '0;
    lookup_tag_i = '0; lookup_index_i = '0;
    mem_awready_i = 1'b0; mem_wready_i = 1'b0; mem_bvalid_i = 1'b0;

    // Reset values.
    #12;
    chk("rst_wb_ready", 64'(wb_ready_o), 64'(1));
    chk("rst_hit", 64'(hit_o), 64'(0));
    chk("rst_awvalid", 64'(mem_awvalid_o), 64'(0));
    chk("rst_wvalid", 64'(mem_wvalid_o), 64'(0));
    chk("rst_wlast", 64'(mem_wlast_o), 64'(0));
    chk("rst_bready", 64'(mem_bready_o), 64'(0));
    chk("rst_addr", 64'(mem_addr_o), 64'(0));
    chk("rst_wdata", 64'(mem_wdata_o), 64'(0));
    rst_n = 1'b1;
    tick();

    // Basic burst, no backpressure.
    clear_logs();
    mem_awready_i = 1'b1; mem_wready_i = 1'b1; mem_bvalid_i = 1'b1;
    lookup_tag_i = 20'hABCDE; lookup_index_i = 8'h5A;
    line_a = 128'h44444444_33333333_22222222_11111111;
    request(20'hABCDE, 8'h5A, line_a);
    chk("basic_hit_capture", 64'(hit_o), 64'(0));
    tick();
    wb_req_i = 1'b0;
    chk("basic_busy", 64'(wb_ready_o), 64'(0));
    n = 0;
    while (!wb_ready_o && n < 100) begin
      chk("basic_hit_busy", 64'(hit_o), 64'(1));
      tick();
      n++;
    end
    chk("basic_occupancy", 64'(n), 64'(6));
    chk("basic_hit_idle", 64'(hit_o), 64'(0));
    chk("basic_aw_count", 64'(log_addr.size()), 64'(1));
    if (log_addr.size() == 1) chk("basic_addr", 64'(log_addr[0]), 64'(32'hABCDE5A0));
    check_burst("basic", 0, line_a);

    // Backpressure, with a lookup differing only in index bit 0.
    clear_logs();
    mem_awready_i = 1'b0; mem_wready_i = 1'b0; mem_bvalid_i = 1'b0;
    line_a = {$urandom, $urandom, $urandom, $urandom};
    lookup_tag_i = 20'h12345; lookup_index_i = 8'hC2;
    request(20'h12345, 8'hC3, line_a);
    tick();
    wb_req_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_awvalid", 64'(mem_awvalid_o), 64'(1));
      chk("bp_addr", 64'(mem_addr_o), 64'(32'h12345C30));
      chk("bp_hit_mismatch", 64'(hit_o), 64'(0));
      tick();
    end
    mem_awready_i = 1'b1;
    tick();
    mem_awready_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      mem_wready_i = wpat[i];
      tick();
    end
    mem_wready_i = 1'b0;
    chk("bp_bready", 64'(mem_bready_o), 64'(1));
    mem_bvalid_i = 1'b1;
    wait_ready("bp", n);
    check_burst("bp", 0, line_a);

    // Requests while busy: during DATA and in the B-handshake cycle.
    clear_logs();
    mem_awready_i = 1'b1; mem_wready_i = 1'b1; mem_bvalid_i = 1'b0;
    line_a = {$urandom, $urandom, $urandom, $urandom};
    line_b = {$urandom, $urandom, $urandom, $urandom};
    request(20'h0F0F0, 8'h11, line_a);
    tick();
    wb_req_i = 1'b0;
    tick();
    request(20'h0AAAA, 8'h22, line_b);
    tick();
    wb_req_i = 1'b0;
    n = 0;
    while (!mem_bready_o && n < 20) begin tick(); n++; end
    chk("busy_reach_resp", 64'(mem_bready_o), 64'(1));
    mem_bvalid_i = 1'b1;
    request(20'h0AAAA, 8'h22, line_b);
    tick();
    chk("busy_ready_after_b", 64'(wb_ready_o), 64'(1));
    tick();
    wb_req_i = 1'b0;
    chk("busy_accept_next", 64'(wb_ready_o), 64'(0));
    wait_ready("busy", n);
    check_burst("busy_first", 0, line_a);
    check_burst("busy_second", 4, line_b);
    chk("busy_aw_count", 64'(log_addr.size()), 64'(2));
    if (log_addr.size() == 2) chk("busy_addr2", 64'(log_addr[1]), 64'(32'h0AAAA220));

    // Reset mid-burst after beat 1 is accepted.
    clear_logs();
    mem_bvalid_i = 1'b0;
    lookup_tag_i = 20'h55555; lookup_index_i = 8'h66;
    line_a = {$urandom, $urandom, $urandom, $urandom};
    request(20'h55555, 8'h66, line_a);
    tick();
    wb_req_i = 1'b0;
    n = 0;
    while (log_data.size() < 2 && n < 20) begin tick(); n++; end
    chk("mrst_two_beats", 64'(log_data.size()), 64'(2));
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_awvalid", 64'(mem_awvalid_o), 64'(0));
    chk("mrst_wvalid", 64'(mem_wvalid_o), 64'(0));
    chk("mrst_wlast", 64'(mem_wlast_o), 64'(0));
    chk("mrst_bready", 64'(mem_bready_o), 64'(0));
    chk("mrst_wb_ready", 64'(wb_ready_o), 64'(1));
    chk("mrst_hit", 64'(hit_o), 64'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("mrst_no_more_beats", 64'(log_data.size()), 64'(2));
    clear_logs();
    line_b = {$urandom, $urandom, $urandom, $urandom};
    request(20'h55555, 8'h66, line_b);
    tick();
    wb_req_i = 1'b0;
    mem_bvalid_i = 1'b1;
    wait_ready("mrst", n);
    check_burst("mrst_restart", 0, line_b);

    // Late response with a spurious bvalid pulse during DATA.
    clear_logs();
    mem_bvalid_i = 1'b0;
    line_a = {$urandom, $urandom, $urandom, $urandom};
    request(20'h00001, 8'h02, line_a);
    tick();
    wb_req_i = 1'b0;
    n = 0;
    while (!mem_wvalid_o && n < 20) begin tick(); n++; end
    mem_wready_i = 1'b0; mem_bvalid_i = 1'b1;
    tick();
    mem_wready_i = 1'b1; mem_bvalid_i = 1'b0;
    chk("late_still_data", 64'(mem_wvalid_o), 64'(1));
    n = 0;
    while (!mem_bready_o && n < 20) begin tick(); n++; end
    for (int i = 0; i < 10; i++) begin
      chk("late_bready_hold", 64'(mem_bready_o), 64'(1));
      chk("late_not_ready", 64'(wb_ready_o), 64'(0));
      tick();
    end
    mem_bvalid_i = 1'b1;
    tick();
    mem_bvalid_i = 1'b0;
    chk("late_done", 64'(wb_ready_o), 64'(1));
    check_burst("late", 0, line_a);

    // Randomized traffic checked by the per-cycle model comparison.
    for (int c = 0; c < 3000; c++) begin
      wb_req_i      = ($urandom_range(0, 3) == 0);
      wb_tag_i      = 20'($urandom);
      wb_index_i    = 8'($urandom);
      wb_line_i     = {$urandom, $urandom, $urandom, $urandom};
      mem_awready_i = ($urandom_range(0, 1) == 1);
      mem_wready_i  = ($urandom_range(0, 2) != 0);
      mem_bvalid_i  = ($urandom_range(0, 2) == 0);
      case ($urandom_range(0, 2))
        0: begin lookup_tag_i = m_tag; lookup_index_i = m_index; end
        1: begin lookup_tag_i = m_tag; lookup_index_i = m_index ^ 8'h01; end
        default: begin lookup_tag_i = 20'($urandom); lookup_index_i = 8'($urandom); end
      endcase
      tick();
    end
    wb_req_i = 1'b0;
    mem_awready_i = 1'b1; mem_wready_i = 1'b1; mem_bvalid_i = 1'b1;
    wait_ready("drain", n);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

endmodule
